// File: rtl/tdc_acq_ctrl.sv
// TDC acquisition controller: gated event counting with coincidence
// classification, followed by a 4-word frame readout over a valid/ready port.
module tdc_acq_ctrl #(
    parameter int         CNT_W  = 32,
    parameter int         GATE_W = 32,
    parameter logic [6:0] WINDOW = 7'd5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_cmd,
    input  logic              abort_cmd,
    input  logic              continuous,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              tdc_data_arrived,
    input  logic [1:0]        tdc_start_signal,
    input  logic [1:0]        tdc_end_signal,
    input  logic [6:0]        tdc_interval,
    output logic              busy,
    output logic              gate_open,
    output logic [CNT_W-1:0]  out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              overflow
);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_COUNT, S_FLUSH, S_OUT} state_t;

    state_t            r_state;
    logic              r_sync1, r_sync2, r_sync3;
    logic              r_ev_vld;
    logic [1:0]        r_ev_start, r_ev_end;
    logic [6:0]        r_ev_int;
    logic [GATE_W-1:0] r_gate;
    logic [1:0]        r_flush;
    logic [1:0]        r_idx;
    logic [CNT_W-1:0]  r_ch1, r_ch2, r_coinc, r_frame_id;
    logic              r_ovf, r_busy, r_gate_open, r_out_valid, r_out_last;
    logic [CNT_W-1:0]  r_out_data;

    logic              w_edge, w_counting;
    logic              w_ch1_hit, w_ch2_hit, w_coinc_hit;
    logic [1:0]        w_idx_nxt;
    logic [CNT_W-1:0]  w_max;
    logic [CNT_W-1:0]  w_words [4];

    assign w_edge     = r_sync2 & ~r_sync3;
    assign w_counting = (r_state == S_COUNT) || (r_state == S_FLUSH);
    assign w_max      = '1;
    assign w_idx_nxt  = r_idx + 2'd1;

    assign w_ch1_hit   = r_ev_vld & r_ev_end[0];
    assign w_ch2_hit   = r_ev_vld & r_ev_end[1];
    assign w_coinc_hit = r_ev_vld &
        (((r_ev_start == 2'b00) && (r_ev_end == 2'b11)) ||
         ((((r_ev_start == 2'b01) && (r_ev_end == 2'b10)) ||
           ((r_ev_start == 2'b10) && (r_ev_end == 2'b01))) && (r_ev_int <= WINDOW)));

    // Frame word 0 carries the overflow flag in place of the frame_id MSB
    assign w_words[0] = {r_ovf, r_frame_id[CNT_W-2:0]};
    assign w_words[1] = r_ch1;
    assign w_words[2] = r_ch2;
    assign w_words[3] = r_coinc;

    assign busy      = r_busy;
    assign gate_open = r_gate_open;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign overflow  = r_ovf;

    // Two-flop synchronizer plus a history flop for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= tdc_data_arrived;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Capture the TDC fields on the detected edge; classified next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ev_vld   <= 1'b0;
            r_ev_start <= '0;
            r_ev_end   <= '0;
            r_ev_int   <= '0;
        end else begin
            r_ev_vld <= w_edge;
            if (w_edge) begin
                r_ev_start <= tdc_start_signal;
                r_ev_end   <= tdc_end_signal;
                r_ev_int   <= tdc_interval;
            end
        end
    end

    // Counters: cleared and frame_id bumped in ARM, saturating counts in COUNT/FLUSH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch1      <= '0;
            r_ch2      <= '0;
            r_coinc    <= '0;
            r_ovf      <= 1'b0;
            r_frame_id <= '0;
        end else if (r_state == S_ARM) begin
            r_ch1      <= '0;
            r_ch2      <= '0;
            r_coinc    <= '0;
            r_ovf      <= 1'b0;
            r_frame_id <= r_frame_id + 1'b1;
        end else if (w_counting) begin
            if (w_ch1_hit) begin
                if (r_ch1 == w_max) r_ovf <= 1'b1;
                else                r_ch1 <= r_ch1 + 1'b1;
            end
            if (w_ch2_hit) begin
                if (r_ch2 == w_max) r_ovf <= 1'b1;
                else                r_ch2 <= r_ch2 + 1'b1;
            end
            if (w_coinc_hit) begin
                if (r_coinc == w_max) r_ovf   <= 1'b1;
                else                  r_coinc <= r_coinc + 1'b1;
            end
        end
    end

    // Acquisition FSM with registered status and output-port signals
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_gate_open <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_gate      <= '0;
            r_flush     <= '0;
            r_idx       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_cmd) begin
                        r_state <= S_ARM;
                        r_busy  <= 1'b1;
                    end
                end
                S_ARM: begin
                    if (abort_cmd) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state     <= S_COUNT;
                        r_gate_open <= 1'b1;
                        // A zero-length gate still opens for one cycle
                        r_gate      <= (gate_len == '0) ? {{(GATE_W-1){1'b0}}, 1'b1} : gate_len;
                    end
                end
                S_COUNT: begin
                    if (abort_cmd) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_gate_open <= 1'b0;
                    end else if (r_gate <= {{(GATE_W-1){1'b0}}, 1'b1}) begin
                        r_state     <= S_FLUSH;
                        r_gate_open <= 1'b0;
                        r_flush     <= 2'd3;
                    end else begin
                        r_gate <= r_gate - 1'b1;
                    end
                end
                S_FLUSH: begin
                    // Lets events already in the synchronizer reach the counters
                    if (abort_cmd) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_flush == 2'd0) begin
                        r_state <= S_OUT;
                        r_idx   <= 2'd0;
                    end else begin
                        r_flush <= r_flush - 2'd1;
                    end
                end
                S_OUT: begin
                    if (abort_cmd) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end else if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_words[r_idx];
                        r_out_last  <= (r_idx == 2'd3);
                    end else if (out_ready) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            if (continuous) begin
                                r_state <= S_ARM;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_idx      <= w_idx_nxt;
                            r_out_data <= w_words[w_idx_nxt];
                            r_out_last <= (w_idx_nxt == 2'd3);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_acq_ctrl.sv
// Bench for tdc_acq_ctrl: a 32-bit and a 4-bit counter instance run in lockstep
// on shared stimulus; expected frames come from a spec-level event model.
`timescale 1ns/10ps
module tb_tdc_acq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1, start_cmd = 1'b0, abort_cmd = 1'b0, continuous = 1'b0;
    logic [31:0] gate_len = '0;
    logic        tdc_data_arrived = 1'b0;
    logic [1:0]  tdc_start_signal = '0, tdc_end_signal = '0;
    logic [6:0]  tdc_interval = '0;
    logic        man_ready = 1'b1, rnd_ready = 1'b0, rnd_bit = 1'b0;
    logic        out_ready;
    logic        busy_a, gate_a, valid_a, last_a, ovf_a;
    logic [31:0] data_a;
    logic        busy_b, gate_b, valid_b, last_b, ovf_b;
    logic [3:0]  data_b;

    assign out_ready = rnd_ready ? rnd_bit : man_ready;

    tdc_acq_ctrl #(.CNT_W(32), .GATE_W(32), .WINDOW(7'd5)) dut_a (
        .clk(clk), .rst(rst), .start_cmd(start_cmd), .abort_cmd(abort_cmd),
        .continuous(continuous), .gate_len(gate_len),
        .tdc_data_arrived(tdc_data_arrived), .tdc_start_signal(tdc_start_signal),
        .tdc_end_signal(tdc_end_signal), .tdc_interval(tdc_interval),
        .busy(busy_a), .gate_open(gate_a), .out_data(data_a), .out_valid(valid_a),
        .out_last(last_a), .out_ready(out_ready), .overflow(ovf_a));

    tdc_acq_ctrl #(.CNT_W(4), .GATE_W(32), .WINDOW(7'd5)) dut_b (
        .clk(clk), .rst(rst), .start_cmd(start_cmd), .abort_cmd(abort_cmd),
        .continuous(continuous), .gate_len(gate_len),
        .tdc_data_arrived(tdc_data_arrived), .tdc_start_signal(tdc_start_signal),
        .tdc_end_signal(tdc_end_signal), .tdc_interval(tdc_interval),
        .busy(busy_b), .gate_open(gate_b), .out_data(data_b), .out_valid(valid_b),
        .out_last(last_b), .out_ready(out_ready), .overflow(ovf_b));

    always #1 clk = ~clk;

    always @(posedge clk) begin
        #0.2;
        rnd_bit = ($urandom_range(0, 1) == 1);
    end

    // Transfer monitor: records every accepted word, plus gate/valid cycle totals
    logic [31:0] qa_d[$];
    logic        qa_l[$];
    logic [3:0]  qb_d[$];
    logic        qb_l[$];
    int          valid_total = 0, gate_total = 0;

    always @(negedge clk) begin
        if (valid_a && out_ready) begin qa_d.push_back(data_a); qa_l.push_back(last_a); end
        if (valid_b && out_ready) begin qb_d.push_back(data_b); qb_l.push_back(last_b); end
        if (valid_a || valid_b) valid_total++;
        if (gate_a) gate_total++;
    end

    int          checks = 0, failures = 0;
    int          rd_a = 0, rd_b = 0;
    logic [31:0] exp_fid = '0;
    int          e1 = 0, e2 = 0, ec = 0;
    int          gate_snap = 0;

    typedef struct {
        logic [1:0] s;
        logic [1:0] e;
        logic [6:0] iv;
        int         c1;
        int         c2;
        int         cc;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #0.1; end
    endtask

    function automatic int is_coinc(input logic [1:0] s, input logic [1:0] e, input logic [6:0] iv);
        if (s == 2'b00 && e == 2'b11) return 1;
        if (((s == 2'b01 && e == 2'b10) || (s == 2'b10 && e == 2'b01)) && iv <= 7'd5) return 1;
        return 0;
    endfunction

    // One TDC event: fields held stable across the synchronizer latency
    task automatic inject(input logic [1:0] s, input logic [1:0] e, input logic [6:0] iv, input bit count);
        tdc_start_signal = s; tdc_end_signal = e; tdc_interval = iv;
        tdc_data_arrived = 1'b1;
        cyc(2);
        tdc_data_arrived = 1'b0;
        cyc(4);
        if (count) begin
            e1 += int'(e[0]);
            e2 += int'(e[1]);
            ec += is_coinc(s, e, iv);
        end
    endtask

    task automatic new_frame_model();
        exp_fid++;
        e1 = 0; e2 = 0; ec = 0;
        gate_snap = gate_total;
    endtask

    // Returns in ARM (start sampled on the preceding edge)
    task automatic start_frame(input int g);
        gate_len = g;
        start_cmd = 1'b1;
        new_frame_model();
        cyc(1);
        start_cmd = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        exp_fid = '0;
        rd_a = qa_d.size();
        rd_b = qb_d.size();
        man_ready = 1'b1;
        rnd_ready = 1'b0;
    endtask

    task automatic wait_words(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            cyc(1);
            if (qa_d.size() - rd_a >= 4 && qb_d.size() - rd_b >= 4) begin ok = 1; break; end
        end
        chk("frame_timeout", ok, 1);
    endtask

    task automatic wait_valid(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            cyc(1);
            if (valid_a) begin ok = 1; break; end
        end
        chk("valid_timeout", ok, 1);
    endtask

    task automatic check_frame(input string tag);
        int          c[4];
        logic [31:0] ea;
        logic [3:0]  eb;
        bit          ovf;
        if (qa_d.size() - rd_a < 4 || qb_d.size() - rd_b < 4) begin
            chk({tag, "_words"}, qa_d.size() - rd_a, 4);
            return;
        end
        c[0] = 0; c[1] = e1; c[2] = e2; c[3] = ec;
        ovf = (e1 > 15) || (e2 > 15) || (ec > 15);
        for (int i = 0; i < 4; i++) begin
            ea = (i == 0) ? {1'b0, exp_fid[30:0]} : c[i];
            eb = (i == 0) ? {ovf, exp_fid[2:0]} : ((c[i] > 15) ? 4'd15 : c[i][3:0]);
            chk($sformatf("%s_a_w%0d", tag, i), qa_d[rd_a + i], ea);
            chk($sformatf("%s_a_last%0d", tag, i), qa_l[rd_a + i], (i == 3));
            chk($sformatf("%s_b_w%0d", tag, i), qb_d[rd_b + i], eb);
            chk($sformatf("%s_b_last%0d", tag, i), qb_l[rd_b + i], (i == 3));
        end
        rd_a += 4;
        rd_b += 4;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] saved_d;
        logic        saved_l;
        int          vsnap, n, g;

        tbl[0]  = '{2'd0, 2'd3, 7'd0,   1, 1, 1};
        tbl[1]  = '{2'd0, 2'd3, 7'd127, 1, 1, 1};
        tbl[2]  = '{2'd1, 2'd2, 7'd5,   0, 1, 1};
        tbl[3]  = '{2'd1, 2'd2, 7'd6,   0, 1, 0};
        tbl[4]  = '{2'd2, 2'd1, 7'd5,   1, 0, 1};
        tbl[5]  = '{2'd2, 2'd1, 7'd0,   1, 0, 1};
        tbl[6]  = '{2'd2, 2'd1, 7'd6,   1, 0, 0};
        tbl[7]  = '{2'd1, 2'd1, 7'd2,   1, 0, 0};
        tbl[8]  = '{2'd3, 2'd3, 7'd0,   1, 1, 0};
        tbl[9]  = '{2'd0, 2'd0, 7'd0,   0, 0, 0};
        tbl[10] = '{2'd2, 2'd2, 7'd1,   0, 1, 0};
        tbl[11] = '{2'd1, 2'd2, 7'd127, 0, 1, 0};

        // Reset state
        cyc(3);
        chk("rst_busy", busy_a, 0);
        chk("rst_gate", gate_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_last", last_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_data_b", data_b, 0);
        rst = 1'b0;
        cyc(2);

        // Basic frame: three coincident events, gate 100
        start_frame(100);
        chk("arm_busy", busy_a, 1);
        chk("arm_gate", gate_a, 0);
        cyc(1);
        chk("count_gate", gate_a, 1);
        repeat (3) inject(2'b00, 2'b11, 7'd0, 1);
        wait_words(300);
        check_frame("basic");
        chk("basic_gatelen", gate_total - gate_snap, 100);
        cyc(1);
        chk("basic_idle_busy", busy_a, 0);

        // Mixed classification
        start_frame(40);
        cyc(1);
        inject(2'b01, 2'b10, 7'd5, 1);
        inject(2'b10, 2'b01, 7'd6, 1);
        inject(2'b01, 2'b01, 7'd2, 1);
        wait_words(200);
        check_frame("mixed");

        // Single-event classification table
        for (int i = 0; i < 12; i++) begin
            start_frame(3);
            cyc(1);
            inject(tbl[i].s, tbl[i].e, tbl[i].iv, 0);
            e1 = tbl[i].c1; e2 = tbl[i].c2; ec = tbl[i].cc;
            wait_words(100);
            check_frame($sformatf("tbl%0d", i));
            cyc(1);
        end

        // Back-pressure: stall word 2 for 10 cycles, with an event arriving in OUT
        man_ready = 1'b0;
        start_frame(10);
        cyc(1);
        inject(2'b00, 2'b11, 7'd0, 1);
        inject(2'b10, 2'b01, 7'd1, 1);
        wait_valid(100);
        man_ready = 1'b1;
        cyc(1);
        man_ready = 1'b0;
        saved_d = data_a;
        saved_l = last_a;
        for (int i = 0; i < 10; i++) begin
            tdc_start_signal = 2'b00; tdc_end_signal = 2'b11; tdc_interval = 7'd0;
            tdc_data_arrived = (i == 1 || i == 2);
            cyc(1);
            chk("stall_valid", valid_a, 1);
            chk("stall_data", data_a, saved_d);
            chk("stall_last", last_a, saved_l);
        end
        man_ready = 1'b1;
        wait_words(50);
        check_frame("stall");
        cyc(10);
        chk("stall_xfers", qa_d.size() - rd_a, 0);

        // Continuous mode: two back-to-back frames
        continuous = 1'b1;
        start_frame(20);
        cyc(1);
        inject(2'b00, 2'b11, 7'd0, 1);
        inject(2'b00, 2'b11, 7'd0, 1);
        wait_words(200);
        chk("cont_arm_busy", busy_a, 1);
        chk("cont_arm_gate", gate_a, 0);
        chk("cont_arm_valid", valid_a, 0);
        check_frame("cont1");
        new_frame_model();
        continuous = 1'b0;
        cyc(1);
        chk("cont_count_gate", gate_a, 1);
        inject(2'b01, 2'b10, 7'd3, 1);
        wait_words(200);
        check_frame("cont2");
        cyc(1);
        chk("cont_idle_busy", busy_a, 0);

        // Abort at gate cycle 10, then a clean frame
        do_reset();
        cyc(2);
        vsnap = valid_total;
        start_frame(50);
        cyc(1);
        inject(2'b00, 2'b11, 7'd0, 1);
        cyc(4);
        abort_cmd = 1'b1;
        cyc(1);
        abort_cmd = 1'b0;
        chk("abort_busy", busy_a, 0);
        chk("abort_gate", gate_a, 0);
        cyc(80);
        chk("abort_no_valid", valid_total - vsnap, 0);
        start_frame(12);
        cyc(1);
        inject(2'b01, 2'b10, 7'd4, 1);
        wait_words(100);
        check_frame("post_abort");
        cyc(2);

        // Abort during OUT drops the frame
        man_ready = 1'b0;
        start_frame(4);
        wait_valid(100);
        abort_cmd = 1'b1;
        cyc(1);
        abort_cmd = 1'b0;
        chk("abort_out_valid", valid_a, 0);
        chk("abort_out_busy", busy_a, 0);
        man_ready = 1'b1;
        vsnap = valid_total;
        cyc(20);
        chk("abort_out_quiet", valid_total - vsnap, 0);

        // Reset during OUT, then frame_id restarts at 1
        man_ready = 1'b0;
        start_frame(4);
        wait_valid(100);
        rst = 1'b1;
        cyc(1);
        chk("rst_out_valid", valid_a, 0);
        chk("rst_out_busy", busy_a, 0);
        chk("rst_out_data", data_a, 0);
        do_reset();
        vsnap = valid_total;
        cyc(20);
        chk("rst_out_quiet", valid_total - vsnap, 0);
        start_frame(8);
        cyc(1);
        inject(2'b00, 2'b11, 7'd9, 1);
        wait_words(100);
        check_frame("post_rst");
        cyc(2);

        // Saturation on the 4-bit instance
        start_frame(130);
        cyc(1);
        repeat (20) inject(2'b00, 2'b11, 7'd0, 1);
        wait_words(200);
        chk("sat_ovf_b", ovf_b, 1);
        chk("sat_ovf_a", ovf_a, 0);
        check_frame("sat");
        cyc(2);

        // Randomized frames with random back-pressure and idle-time events
        rnd_ready = 1'b1;
        for (int f = 0; f < 10; f++) begin
            n = $urandom_range(0, 4);
            g = (n == 0) ? $urandom_range(0, 3) : 6 * n - 5 + $urandom_range(0, 8);
            inject(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 7'($urandom_range(0, 9)), 0);
            start_frame(g);
            cyc(1);
            for (int k = 0; k < n; k++)
                inject(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 7'($urandom_range(0, 9)), 1);
            wait_words(g + 300);
            chk($sformatf("rnd%0d_gatelen", f), gate_total - gate_snap, (g == 0) ? 1 : g);
            check_frame($sformatf("rnd%0d", f));
            cyc(2);
            chk($sformatf("rnd%0d_idle", f), busy_a, 0);
        end
        rnd_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdc_acq_ctrl.md
TDC_ACQ_CTRL -- requirements
Module: tdc_acq_ctrl

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- CNT_W, 32, width of the event and coincidence counters and of the output word.
- GATE_W, 32, width of the gate length in clk cycles.
- WINDOW, 7'd5, maximum TDC INTERVAL (2 ns units) counted as a coincidence.

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, 500 MHz system clock; the only clock.
- rst, in, 1, synchronous, active-high reset.
- start_cmd, in, 1, single-cycle request to begin an acquisition.
- abort_cmd, in, 1, single-cycle request to abandon the current acquisition.
- continuous, in, 1, when 1, re-arm automatically after each frame is read out.
- gate_len, in, GATE_W, gate duration in clk cycles; sampled at arm.
- tdc_data_arrived, in, 1, TDC event flag; asynchronous to clk.
- tdc_start_signal, in, 2, TDC START channel field.
- tdc_end_signal, in, 2, TDC END channel field.
- tdc_interval, in, 7, TDC interval field.
- busy, out, 1, high in any state other than IDLE.
- gate_open, out, 1, high only in COUNT.
- out_data, out, CNT_W, result word.
- out_valid, out, 1, out_data is valid.
- out_last, out, 1, marks the final word of a frame.
- out_ready, in, 1, downstream accepts out_data.
- overflow, out, 1, sticky flag: a counter saturated in the current frame.

Function
REQ-003 tdc_data_arrived SHALL pass through a 2-flop synchronizer; an event is the rising edge of the synchronized signal, detected one cycle later.
REQ-004 On an event, the block SHALL register tdc_start_signal, tdc_end_signal and tdc_interval in the same cycle the edge is detected; the registered event is classified and counted on the following cycle.
REQ-005 The FSM SHALL have the states IDLE, ARM, COUNT, FLUSH and OUT.
REQ-006 In IDLE, start_cmd SHALL move the FSM to ARM; start_cmd in any other state SHALL be ignored.
REQ-007 ARM SHALL last 1 cycle and SHALL:
- clear all counters and overflow;
- load the gate counter with gate_len;
- capture frame_id, which increments by 1 at every ARM and wraps at 2^CNT_W.
REQ-008 gate_len = 0 SHALL be treated as 1.
REQ-009 COUNT SHALL last exactly the latched gate_len cycles; only events whose classification cycle falls in COUNT or FLUSH are counted.
REQ-010 FLUSH SHALL last 4 cycles so that edges already inside the synchronizer pipeline are counted; the FSM then moves to OUT.
REQ-011 Classification of each counted event:
- ch1_cnt += 1 if end[0] = 1;
- ch2_cnt += 1 if end[1] = 1 (both can increment on the same event);
- coinc_cnt += 1 if (start = 00 and end = 11), or if (start, end) is (01, 10) or (10, 01) and interval <= WINDOW.
REQ-012 Counters SHALL saturate at 2^CNT_W - 1 and never wrap; a saturating increment SHALL set overflow.
REQ-013 OUT SHALL emit 4 words in order: frame_id, ch1_cnt, ch2_cnt, coinc_cnt.
- Bits [CNT_W-1] of frame_id are replaced by overflow.
- out_last is high with the 4th word only.
REQ-014 Output handshake:
- A word transfers when out_valid and out_ready are both high.
- out_data, out_valid and out_last SHALL hold stable while out_valid = 1 and out_ready = 0.
- out_valid SHALL be registered and never depend combinationally on out_ready.
REQ-015 After the 4th transfer, the FSM SHALL go to ARM if continuous = 1, else to IDLE.
REQ-016 abort_cmd in ARM, COUNT or FLUSH SHALL go to IDLE next cycle, discard counts and emit no frame.
REQ-017 abort_cmd in OUT SHALL drop out_valid next cycle and go to IDLE; a partially sent frame is not completed.
REQ-018 An event coinciding with the COUNT-to-FLUSH transition SHALL be counted exactly once.
REQ-019 Events in IDLE or OUT SHALL NOT alter the counters.
REQ-020 busy SHALL be 0 exactly in IDLE; gate_open SHALL be 1 exactly in COUNT.

Reset
REQ-021 While rst = 1 at a clk edge, the block SHALL set:
- FSM = IDLE;
- busy, gate_open, out_valid, out_last, overflow = 0;
- out_data, all counters, frame_id = 0;
- synchronizer flops = 0.
REQ-022 rst mid-acquisition or mid-OUT SHALL abandon the frame with no further output; the first frame after reset SHALL carry frame_id 1.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset, gate_len=100, start_cmd, 3 events (start 00/end 11/int 0) in COUNT, out_ready=1 -> words 1, 3, 3, 3; out_last on 4th word; then IDLE with busy=0.
- Events (01,10,int 5), (10,01,int 6), (01,01,int 2) -> ch1=2, ch2=1, coinc=1.
- out_ready held 0 for 10 cycles during word 2 -> out_data and out_valid stable; on release, exactly 4 transfers total.
- continuous=1, gate_len=20, 2 frames -> frame_ids 1 and 2; ARM occurs 1 cycle after each out_last transfer; counts are independent per frame.
- abort_cmd at gate cycle 10 -> no out_valid; the next frame carries frame_id 2 with counts from that frame only.
- CNT_W=4, 20 coincident events -> ch1=ch2=coinc=15 and the frame_id MSB is 1 (overflow).
